blink_rate_decoder: RTL and testbench
=====================================

BLINK_RATE_DECODER -- requirements
Module: blink_rate_decoder

Interface
REQ-001 Parameter HALF1, default 50_000_000, is the nominal half-period of rate class 1 (1 Hz at 100 MHz) in clk cycles.
REQ-002 Parameter HALF2, default 25_000_000, is the nominal half-period of rate class 2 in clk cycles.
REQ-003 Parameter HALF3, default 16_666_667, is the nominal half-period of rate class 3 in clk cycles.
REQ-004 Parameter HALF4, default 12_500_000, is the nominal half-period of rate class 4 in clk cycles.
REQ-005 Parameter TOL, default 1_000, is the accepted deviation in cycles; the windows [HALFk-TOL, HALFk+TOL] SHALL be disjoint, and a violation SHALL cause an elaboration error.
REQ-006 clk  input  1  single clock; all logic is on its rising edge.
REQ-007 rst_n  input  1  reset, synchronous and active-low.
REQ-008 sig_in  input  8  asynchronous square-wave inputs, one per channel.
REQ-009 rate  output  24  per-channel rate code; channel i uses bits [3i+2:3i]; 0 = none, 1..4 = class.
REQ-010 lock  output  8  per-channel flag; high while that channel's rate is non-zero.
REQ-011 upd  output  8  per-channel one-cycle pulse whenever that channel's rate value changes.

Function
REQ-012 Each channel SHALL be independent and identical (generate loop); no channel affects another.
REQ-013 Each sig_in bit SHALL pass through a 2-FF synchronizer plus one delay FF; edge = stage2 XOR stage3, both polarities, 3-cycle pin-to-edge latency.
REQ-014 Per-channel 32-bit counter N SHALL equal the number of clk cycles between consecutive detected edges; an input toggling every H cycles SHALL measure N = H.
REQ-015 Classification: class k if HALFk-TOL <= N <= HALFk+TOL, else class 0.
REQ-016 Per-channel FSM states IDLE, SEARCH, ARMED, LOCKED, plus a 3-bit candidate register.
REQ-017 IDLE: on edge -> SEARCH, counter restarts; no classification of the first edge.
REQ-018 SEARCH: on edge with class k != 0 -> ARMED, candidate = k; class 0 -> remain SEARCH.
REQ-019 ARMED: edge with class == candidate -> LOCKED, rate = k, lock = 1, upd pulse; class != 0 and != candidate -> ARMED, candidate = new class; class 0 -> SEARCH.
REQ-020 LOCKED: edge with class == rate -> stay, no upd; any other class -> rate = 0, lock = 0, upd pulse, then follow REQ-019's mismatch rules (new nonzero class -> ARMED, candidate = new class; 0 -> SEARCH).
REQ-021 Timeout: in SEARCH/ARMED/LOCKED, when the counter reaches HALF1+TOL+1 without an edge -> IDLE; if LOCKED, clear rate and lock and pulse upd in the same cycle.
REQ-022 The counter SHALL saturate and never wrap; an edge arriving in the same cycle as the timeout SHALL be processed as an edge, and the timeout is ignored.
REQ-023 rate, lock and upd SHALL update on the clock edge following the cycle in which the internal edge is detected.
REQ-024 upd SHALL never pulse when rate is unchanged.

Reset
REQ-025 While rst_n is low at a clk edge, the block SHALL clear all synchronizer/delay FFs, counters and candidates, set every FSM to IDLE, and drive rate = 0, lock = 0 and upd = 0.
REQ-026 Reset asserted mid-lock SHALL clear outputs on that clock edge with no upd pulse.
REQ-027 After reset release, an input already high SHALL produce one spurious edge, which only moves the FSM IDLE -> SEARCH.

Verification (HALF1=40, HALF2=20, HALF3=13, HALF4=10, TOL=1)
REQ-028 Toggle sig_in[0] every 20 cycles -> on the 3rd detected edge: rate[2:0] = 2, lock[0] = 1, exactly one upd[0] pulse; all other channels stay 0.
REQ-029 Drive channels 0..7 with half-periods 40,40,20,20,13,13,10,10 -> rate = {4,4,3,3,2,2,1,1} (ch7..ch0), lock = 8'hFF, each upd bit pulsed once.
REQ-030 Lock ch0 at class 2, then hold sig_in[0] static -> 42 cycles after the last edge, rate[2:0] = 0, lock[0] = 0, one upd[0] pulse, FSM in IDLE.
REQ-031 Half-period 16 (outside every window), and separately 11/12 jitter alternating between class 4 and class 3 -> rate stays 0, no upd.
REQ-032 Locked at class 4 (10), switch to 13 -> first 13-cycle measurement: rate = 0 with upd; second: rate = 3 with upd.
REQ-033 Assert rst_n low for 1 cycle while 8 channels are locked -> next edge: rate = 0, lock = 0, no upd; relock per REQ-027/028.

Source files
------------

// File: rtl/blink_rate_decoder_if.sv
// Bundle of the per-channel square-wave inputs and the decoded rate outputs.
interface blink_rate_decoder_if;
  logic [7:0]  sig_in;
  logic [23:0] rate;
  logic [7:0]  lock;
  logic [7:0]  upd;

  modport master (output sig_in, input rate, input lock, input upd);
  modport slave  (input sig_in, output rate, output lock, output upd);
endinterface

// File: rtl/blink_rate_decoder.sv
// Eight independent blink-rate decoders: each channel measures the spacing between edges
// of its input, classifies it into one of four rate windows and locks once two consecutive
// measurements agree.
module blink_rate_decoder #(
  parameter int unsigned HALF1 = 50_000_000,
  parameter int unsigned HALF2 = 25_000_000,
  parameter int unsigned HALF3 = 16_666_667,
  parameter int unsigned HALF4 = 12_500_000,
  parameter int unsigned TOL   = 1_000
) (
  input logic                 clk,
  input logic                 rst_n,
  blink_rate_decoder_if.slave bus
);

  localparam int unsigned NumCh = 8;

  // All window arithmetic is done in 64 bits so HALFk+TOL can never overflow.
  localparam logic [63:0] H1 = 64'(HALF1);
  localparam logic [63:0] H2 = 64'(HALF2);
  localparam logic [63:0] H3 = 64'(HALF3);
  localparam logic [63:0] H4 = 64'(HALF4);
  localparam logic [63:0] T  = 64'(TOL);

  function automatic logic [63:0] abs_diff(input logic [63:0] a, input logic [63:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Two windows of half-width TOL are disjoint iff their centres differ by more than 2*TOL.
  localparam bit WindowsOk = (abs_diff(H1, H2) > 2 * T) && (abs_diff(H1, H3) > 2 * T) &&
                             (abs_diff(H1, H4) > 2 * T) && (abs_diff(H2, H3) > 2 * T) &&
                             (abs_diff(H2, H4) > 2 * T) && (abs_diff(H3, H4) > 2 * T);

  if (!WindowsOk) begin : g_bad_windows
    $error("blink_rate_decoder: rate windows [HALFk-TOL, HALFk+TOL] overlap");
  end

  localparam logic [63:0] Lo1 = (H1 > T) ? H1 - T : 64'd0;
  localparam logic [63:0] Lo2 = (H2 > T) ? H2 - T : 64'd0;
  localparam logic [63:0] Lo3 = (H3 > T) ? H3 - T : 64'd0;
  localparam logic [63:0] Lo4 = (H4 > T) ? H4 - T : 64'd0;
  localparam logic [63:0] Hi1 = H1 + T;
  localparam logic [63:0] Hi2 = H2 + T;
  localparam logic [63:0] Hi3 = H3 + T;
  localparam logic [63:0] Hi4 = H4 + T;
  // Longer than the slowest accepted half-period: the signal is considered dead.
  localparam logic [63:0] TimeoutCnt = H1 + T + 64'd1;

  typedef enum logic [1:0] {StIdle, StSearch, StArmed, StLocked} state_e;

  for (genvar i = 0; i < NumCh; i++) begin : g_ch
    logic        s1_q, s2_q, s3_q;
    logic        edge_det;
    logic [31:0] cnt_q;
    logic [63:0] cnt_ext;
    logic [2:0]  cls;
    logic        timeout;
    state_e      state_q;
    logic [2:0]  cand_q;
    logic [2:0]  rate_q;
    logic        lock_q;
    logic        upd_q;

    // Two-flop synchronizer plus a delay stage for edge detection.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1_q <= 1'b0;
        s2_q <= 1'b0;
        s3_q <= 1'b0;
      end else begin
        s1_q <= bus.sig_in[i];
        s2_q <= s1_q;
        s3_q <= s2_q;
      end
    end

    assign edge_det = s2_q ^ s3_q;

    // Cycles since the last edge; restarts at 1 so the value seen at the next edge equals
    // the spacing, and saturates instead of wrapping.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q <= 32'd0;
      end else if (edge_det) begin
        cnt_q <= 32'd1;
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end

    assign cnt_ext = {32'd0, cnt_q};
    assign timeout = (cnt_ext >= TimeoutCnt);

    // Map the measured spacing onto a rate class (0 = outside every window).
    always_comb begin
      cls = 3'd0;
      if (cnt_ext >= Lo1 && cnt_ext <= Hi1) begin
        cls = 3'd1;
      end else if (cnt_ext >= Lo2 && cnt_ext <= Hi2) begin
        cls = 3'd2;
      end else if (cnt_ext >= Lo3 && cnt_ext <= Hi3) begin
        cls = 3'd3;
      end else if (cnt_ext >= Lo4 && cnt_ext <= Hi4) begin
        cls = 3'd4;
      end
    end

    // Lock FSM with registered rate/lock/upd; an edge always wins over a timeout.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= StIdle;
        cand_q  <= 3'd0;
        rate_q  <= 3'd0;
        lock_q  <= 1'b0;
        upd_q   <= 1'b0;
      end else begin
        upd_q <= 1'b0;
        if (edge_det) begin
          unique case (state_q)
            StIdle: begin
              state_q <= StSearch;
            end
            StSearch: begin
              if (cls != 3'd0) begin
                state_q <= StArmed;
                cand_q  <= cls;
              end
            end
            StArmed: begin
              if (cls == cand_q) begin
                state_q <= StLocked;
                rate_q  <= cls;
                lock_q  <= 1'b1;
                upd_q   <= 1'b1;
              end else if (cls != 3'd0) begin
                cand_q <= cls;
              end else begin
                state_q <= StSearch;
              end
            end
            StLocked: begin
              if (cls != rate_q) begin
                rate_q <= 3'd0;
                lock_q <= 1'b0;
                upd_q  <= 1'b1;
                if (cls != 3'd0) begin
                  state_q <= StArmed;
                  cand_q  <= cls;
                end else begin
                  state_q <= StSearch;
                end
              end
            end
            default: state_q <= StIdle;
          endcase
        end else if (timeout && state_q != StIdle) begin
          state_q <= StIdle;
          if (state_q == StLocked) begin
            rate_q <= 3'd0;
            lock_q <= 1'b0;
            upd_q  <= 1'b1;
          end
        end
      end
    end

    assign bus.rate[3*i +: 3] = rate_q;
    assign bus.lock[i]        = lock_q;
    assign bus.upd[i]         = upd_q;
  end

endmodule

// File: tb/tb_blink_rate_decoder.sv
// Directed bench for blink_rate_decoder using small half-periods (40/20/13/10, TOL 1).
module tb_blink_rate_decoder;

  logic clk;
  logic rst_n;

  blink_rate_decoder_if bus ();

  blink_rate_decoder #(
    .HALF1 (40),
    .HALF2 (20),
    .HALF3 (13),
    .HALF4 (10),
    .TOL   (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-channel square-wave generator state: alternating half-periods a/b, 0 = hold level.
  int         half_a [8];
  int         half_b [8];
  int         tcnt   [8];
  bit         ph     [8];
  logic [7:0] sig;

  // Running count of upd pulses per channel, sampled mid-cycle.
  int upd_cnt [8];
  int base    [8];

  initial begin
    for (int c = 0; c < 8; c++) upd_cnt[c] = 0;
  end

  always @(negedge clk) begin
    for (int c = 0; c < 8; c++) upd_cnt[c] = upd_cnt[c] + int'(bus.upd[c]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_half(input int c, input int a, input int b);
    half_a[c] = a;
    half_b[c] = b;
    tcnt[c]   = 0;
    ph[c]     = 1'b0;
  endtask

  // Advance n cycles; inputs change and checks happen just after each falling edge.
  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      for (int c = 0; c < 8; c++) begin
        if (half_a[c] != 0) begin
          tcnt[c]++;
          if (tcnt[c] >= (ph[c] ? half_b[c] : half_a[c])) begin
            sig[c]  = ~sig[c];
            tcnt[c] = 0;
            ph[c]   = ~ph[c];
          end
        end
      end
      bus.sig_in = sig;
    end
  endtask

  task automatic snap();
    for (int c = 0; c < 8; c++) base[c] = upd_cnt[c];
  endtask

  function automatic logic [31:0] dupd(input int c);
    return 32'(upd_cnt[c] - base[c]);
  endfunction

  initial begin
    for (int c = 0; c < 8; c++) set_half(c, 0, 0);
    sig        = 8'h00;
    bus.sig_in = sig;
    rst_n      = 1'b0;
    cycles(3);
    chk("reset_rate", {8'd0, bus.rate}, 32'd0);
    chk("reset_lock", {24'd0, bus.lock}, 32'd0);
    chk("reset_upd",  {24'd0, bus.upd}, 32'd0);
    rst_n = 1'b1;

    // Channel 0 toggling every 20 cycles: edges at 20/40/60, lock visible 3 cycles later.
    snap();
    set_half(0, 20, 20);
    cycles(62);
    chk("c0_before_lock", {29'd0, bus.rate[2:0]}, 32'd0);
    cycles(1);
    chk("c0_rate2", {29'd0, bus.rate[2:0]}, 32'd2);
    chk("c0_lock",  {31'd0, bus.lock[0]}, 32'd1);
    chk("c0_upd",   {24'd0, bus.upd}, 32'h01);
    chk("others_rate", {11'd0, bus.rate[23:3]}, 32'd0);
    chk("others_lock", {25'd0, bus.lock[7:1]}, 32'd0);
    cycles(1);
    chk("c0_upd_one_cycle", {24'd0, bus.upd}, 32'd0);
    cycles(100);
    chk("c0_still_rate2", {29'd0, bus.rate[2:0]}, 32'd2);
    chk("c0_single_upd", dupd(0), 32'd1);

    // Hold channel 0 static: last toggle at 160, timeout 42 cycles after that edge.
    set_half(0, 0, 0);
    cycles(40);
    chk("c0_pre_timeout_rate", {29'd0, bus.rate[2:0]}, 32'd2);
    chk("c0_pre_timeout_lock", {31'd0, bus.lock[0]}, 32'd1);
    cycles(1);
    chk("c0_timeout_rate", {29'd0, bus.rate[2:0]}, 32'd0);
    chk("c0_timeout_lock", {31'd0, bus.lock[0]}, 32'd0);
    chk("c0_timeout_upd",  {24'd0, bus.upd}, 32'h01);
    cycles(2);
    chk("c0_timeout_upd_count", dupd(0), 32'd2);

    // Half-period 16 on ch1 and 11/12 jitter on ch2: never lock, never pulse.
    snap();
    set_half(1, 16, 16);
    set_half(2, 11, 12);
    cycles(200);
    chk("ch1_16_rate", {29'd0, bus.rate[5:3]}, 32'd0);
    chk("ch2_jit_rate", {29'd0, bus.rate[8:6]}, 32'd0);
    chk("ch1_16_upd", dupd(1), 32'd0);
    chk("ch2_jit_upd", dupd(2), 32'd0);
    set_half(1, 0, 0);
    set_half(2, 0, 0);

    // Ch3 locked at class 4, then half-period switched to 13.
    snap();
    set_half(3, 10, 10);
    cycles(40);
    chk("c3_rate4", {29'd0, bus.rate[11:9]}, 32'd4);
    chk("c3_upd_lock", dupd(3), 32'd1);
    set_half(3, 13, 13);
    cycles(15);
    chk("c3_hold4", {29'd0, bus.rate[11:9]}, 32'd4);
    cycles(1);
    chk("c3_drop_rate", {29'd0, bus.rate[11:9]}, 32'd0);
    chk("c3_drop_upd",  {24'd0, bus.upd}, 32'h08);
    cycles(12);
    chk("c3_armed_rate", {29'd0, bus.rate[11:9]}, 32'd0);
    cycles(1);
    chk("c3_rate3", {29'd0, bus.rate[11:9]}, 32'd3);
    chk("c3_rate3_upd", {24'd0, bus.upd}, 32'h08);
    cycles(2);
    chk("c3_upd_total", dupd(3), 32'd3);

    // Clean restart, then all eight channels at mixed rates.
    for (int c = 0; c < 8; c++) set_half(c, 0, 0);
    sig        = 8'h00;
    bus.sig_in = sig;
    rst_n      = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    snap();
    set_half(0, 40, 40);
    set_half(1, 40, 40);
    set_half(2, 20, 20);
    set_half(3, 20, 20);
    set_half(4, 13, 13);
    set_half(5, 13, 13);
    set_half(6, 10, 10);
    set_half(7, 10, 10);
    cycles(130);
    chk("all_rate", {8'd0, bus.rate}, {8'd0, 3'd4, 3'd4, 3'd3, 3'd3, 3'd2, 3'd2, 3'd1, 3'd1});
    chk("all_lock", {24'd0, bus.lock}, 32'hFF);
    for (int c = 0; c < 8; c++) chk($sformatf("all_upd_ch%0d", c), dupd(c), 32'd1);

    // One-cycle reset while every channel is locked, then relock.
    snap();
    rst_n = 1'b0;
    cycles(1);
    chk("rst_mid_rate", {8'd0, bus.rate}, 32'd0);
    chk("rst_mid_lock", {24'd0, bus.lock}, 32'd0);
    chk("rst_mid_upd",  {24'd0, bus.upd}, 32'd0);
    rst_n = 1'b1;
    cycles(4);
    chk("post_rst_rate", {8'd0, bus.rate}, 32'd0);
    for (int c = 0; c < 8; c++) chk($sformatf("rst_no_upd_ch%0d", c), dupd(c), 32'd0);
    cycles(250);
    chk("relock_rate", {8'd0, bus.rate}, {8'd0, 3'd4, 3'd4, 3'd3, 3'd3, 3'd2, 3'd2, 3'd1, 3'd1});
    chk("relock_lock", {24'd0, bus.lock}, 32'hFF);
    for (int c = 0; c < 8; c++) chk($sformatf("relock_upd_ch%0d", c), dupd(c), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
